card_shoe: RTL and testbench
============================

Name: card_shoe

Overview:
- Card source for the 21 game: holds a full deck, shuffles it, and deals cards one at a time on request, without replacement.
- It is the producer end of the draw interface. The game control asserts a draw request; this block returns one card (rank plus suit) with a valid strobe.
- Rank encoding is 1..13, so it drives the existing 4-bit card-value path and the two-digit hex display directly.

Parameters:
- DECK_SIZE, 52: number of cards in the shoe; must be a multiple of 13 and at most 63.
- LFSR_SEED, 16'hACE1: value loaded into the shuffle LFSR on reset; must be nonzero.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- shuffle_req  in  1  level or pulse; start re-initialise and shuffle
- draw_req  in  1  request one card; sampled each cycle while ready=1
- card_valid  out  1  one-cycle strobe; card_rank and card_suit are valid
- card_rank  out  4  1..13; holds the last dealt value
- card_suit  out  2  0..3; holds the last dealt value
- cards_left  out  6  number of undealt cards
- ready  out  1  idle and able to accept a draw
- empty  out  1  ready=1 and cards_left=0
- draw_err  out  1  one-cycle pulse when a draw is requested while empty

Behaviour:
- Storage is a register array deck[0..DECK_SIZE-1], each entry {suit[1:0], rank[3:0]}, plus a deal pointer ptr[5:0].
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Loaded with LFSR_SEED on reset; advances every cycle in every state.
  - Because it runs during READY, the shuffle result depends on when the user presses the key.
- Reset, taking effect on the next edge:
  - state=INIT, index i=0, ptr=0.
  - card_valid=0, card_rank=0, card_suit=0, cards_left=0.
  - ready=0, empty=0, draw_err=0.
  - Reset mid-INIT, mid-SHUFFLE or mid-deal aborts and restarts cleanly. Nothing from the previous deck survives.
- States:
  - INIT: one entry per cycle: deck[i] = {i/13, (i%13)+1}, i=0..DECK_SIZE-1, so DECK_SIZE cycles. Then i=DECK_SIZE-1 and go to SHUFFLE.
  - SHUFFLE: Fisher-Yates, one candidate per cycle.
    - Candidate j = lfsr[5:0] & mask(i), where mask(i) is the smallest all-ones value >= i.
    - If j > i, reject and retry next cycle.
    - If j <= i, swap deck[i] and deck[j] in the same cycle, then decrement i.
    - When i reaches 0 and the swap is done, go to READY with ptr=0 and cards_left=DECK_SIZE.
    - Expected fewer than 2 cycles per position. No upper bound is required, but the LFSR period guarantees termination.
  - READY: ready=1.
    - draw_req=1 with cards_left>0: on the next edge, card_valid=1 for exactly one cycle, {card_suit, card_rank}=deck[ptr], ptr+1, cards_left-1. Latency from request to valid is 1 cycle.
    - A draw_req held high deals one card per cycle. The game's edge detect is the caller's job.
    - draw_req=1 with cards_left=0: no card_valid, outputs hold, draw_err pulses 1 cycle, and the block stays in READY.
    - shuffle_req=1: go to INIT on the next edge; ready=0, cards_left=0.
- Simultaneous shuffle_req and draw_req in READY: shuffle wins, no card is dealt, and card_valid stays 0.
- Requests while busy:
  - draw_req while not ready (INIT or SHUFFLE) is ignored. It is not queued, raises no draw_err, and produces no card_valid.
  - shuffle_req while busy is ignored; the shuffle in progress completes.
- Output timing:
  - ready and empty are registered.
  - empty = (state==READY && cards_left==0), and goes high in the same cycle as the card_valid of the last card.
- Width rule: cards_left never wraps. Decrement is only allowed when it is nonzero.

Test Plan:
- Reset held 1 cycle, then wait for ready: ready=0 for at least DECK_SIZE+51 cycles, then ready=1 with cards_left=52, empty=0, card_rank=0.
- 52 single-cycle draws spaced 3 cycles apart:
  - 52 card_valid pulses, each 1 cycle after its request.
  - Every {suit, rank} pair with rank 1..13 appears exactly once.
  - cards_left steps 52 down to 0; empty=1 after the 52nd.
  - The sequence is not the identity order 1,2,…,13 for suit 0.
- 53rd draw: card_valid stays 0, draw_err=1 for 1 cycle, card_rank holds the 52nd value, cards_left=0.
- After 10 draws, pulse shuffle_req with draw_req=1 in the same cycle:
  - No card_valid; ready=0 next cycle.
  - On return to ready, cards_left=52; drawing all 52 again yields a full permutation.
- draw_req held high for 20 cycles during SHUFFLE: no card_valid, no draw_err, and cards_left=0 until ready.
- Reset asserted mid-SHUFFLE and again after 5 draws: next cycle ready=0, cards_left=0, card_valid=0, card_rank=0. Same seed and same reset-to-draw timing reproduce an identical deal order.

Source files
------------

// File: rtl/card_shoe.sv
// card_shoe: deck storage, Fisher-Yates shuffler and dealer for the 21 game.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high; restarts INIT from scratch
//   shuffle_req  start a re-initialise and shuffle (acted on only when ready)
//   draw_req     request one card; sampled every cycle while ready
//   card_valid   one-cycle strobe; card_rank/card_suit carry the new card
//   card_rank    1..13, holds the last dealt value
//   card_suit    0..3, holds the last dealt value
//   cards_left   number of undealt cards
//   ready        idle and able to accept a draw
//   empty        ready and no cards left
//   draw_err     one-cycle pulse for a draw requested while empty
module card_shoe #(
  parameter int          DECK_SIZE = 52,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       shuffle_req,
  input  logic       draw_req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       ready,
  output logic       empty,
  output logic       draw_err
);

  typedef enum logic [1:0] {S_INIT, S_SHUFFLE, S_READY} state_t;

  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL = 6'(DECK_SIZE);

  state_t      state, state_nx;
  logic [5:0]  deck [DECK_SIZE];   // {suit, rank}
  logic [5:0]  idx;
  logic [5:0]  ptr;
  logic [15:0] lfsr;
  logic [1:0]  init_suit;
  logic [3:0]  init_rank;
  logic [5:0]  mask;
  logic [5:0]  cand;
  logic        accept;
  logic        deal;
  logic        err;
  logic [5:0]  left_nx;

  // Smallest all-ones value >= v: smear the leading one downward.
  function automatic logic [5:0] mask_of(input logic [5:0] v);
    logic [5:0] m;
    m = v;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  assign mask   = mask_of(idx);
  assign cand   = lfsr[5:0] & mask;
  assign accept = (cand <= idx);

  always_ff @(posedge clock) begin
    if (reset) state <= S_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    deal     = 1'b0;
    err      = 1'b0;
    left_nx  = cards_left;
    case (state)
      S_INIT:    if (idx == LAST) state_nx = S_SHUFFLE;
      S_SHUFFLE: begin
        // Swap at position 1 is the last useful one; position 0 can only
        // swap with itself, so go straight to READY.
        if (accept && idx == 6'd1) begin
          state_nx = S_READY;
          left_nx  = FULL;
        end
      end
      S_READY: begin
        if (shuffle_req) begin
          state_nx = S_INIT;
          left_nx  = 6'd0;
        end else if (draw_req) begin
          if (cards_left != 6'd0) begin
            deal    = 1'b1;
            left_nx = cards_left - 6'd1;
          end else begin
            err = 1'b1;
          end
        end
      end
      default: begin
        state_nx = S_INIT;
        left_nx  = 6'd0;
      end
    endcase
  end

  // Galois LFSR, x^16+x^14+x^13+x^11+1; free-running in every state so
  // the shuffle outcome depends on when the user asks for it.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx        <= 6'd0;
      ptr        <= 6'd0;
      init_suit  <= 2'd0;
      init_rank  <= 4'd1;
      card_valid <= 1'b0;
      card_rank  <= 4'd0;
      card_suit  <= 2'd0;
      cards_left <= 6'd0;
      ready      <= 1'b0;
      empty      <= 1'b0;
      draw_err   <= 1'b0;
    end else begin
      card_valid <= deal;
      draw_err   <= err;
      cards_left <= left_nx;
      ready      <= (state_nx == S_READY);
      empty      <= (state_nx == S_READY) && (left_nx == 6'd0);
      case (state)
        S_INIT: begin
          deck[idx] <= {init_suit, init_rank};
          if (init_rank == 4'd13) begin
            init_rank <= 4'd1;
            init_suit <= init_suit + 2'd1;
          end else begin
            init_rank <= init_rank + 4'd1;
          end
          if (idx != LAST) idx <= idx + 6'd1;
        end
        S_SHUFFLE: begin
          if (accept) begin
            deck[idx]  <= deck[cand];
            deck[cand] <= deck[idx];
            idx        <= idx - 6'd1;
            if (idx == 6'd1) ptr <= 6'd0;
          end
        end
        S_READY: begin
          if (shuffle_req) begin
            idx       <= 6'd0;
            ptr       <= 6'd0;
            init_suit <= 2'd0;
            init_rank <= 4'd1;
          end else if (deal) begin
            {card_suit, card_rank} <= deck[ptr];
            ptr <= ptr + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: stimulus pushes expected dealt-card timing and
// cards_left into a queue; a negedge monitor pops on every card_valid.
module tb_card_shoe;

  localparam int DECK = 52;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       shuffle_req = 1'b0;
  logic       draw_req = 1'b0;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [5:0] cards_left;
  logic       ready;
  logic       empty;
  logic       draw_err;

  card_shoe #(.DECK_SIZE(DECK), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .shuffle_req(shuffle_req),
    .draw_req(draw_req), .card_valid(card_valid), .card_rank(card_rank),
    .card_suit(card_suit), .cards_left(cards_left), .ready(ready),
    .empty(empty), .draw_err(draw_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int left;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] log_q[$];
  int         cyc = 0;
  int         err_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (draw_err) err_cnt++;
    if (card_valid) begin
      check(exp_q.size() != 0, "valid_expected", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(cyc == e.cyc, "valid_latency", cyc, e.cyc);
        check(int'(cards_left) == e.left, "cards_left_step", cards_left, e.left);
        check(empty == (e.left == 0), "empty_with_valid", empty, e.left == 0);
        log_q.push_back({card_suit, card_rank});
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic check_reset_state(input string nm);
    check(ready == 1'b0 && cards_left == 6'd0 && card_valid == 1'b0 &&
          card_rank == 4'd0 && card_suit == 2'd0 && empty == 1'b0 && draw_err == 1'b0,
          nm, {ready, cards_left, card_valid, card_rank}, 0);
  endtask

  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (n < 5000 && !ready) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(ready == 1'b1, {nm, "_timeout"}, n, 5000);
  endtask

  task automatic draw(input int left_after);
    @(posedge clock);
    #1 draw_req = 1'b1;
    exp_q.push_back('{cyc: cyc + 1, left: left_after});
    @(posedge clock);
    #1 draw_req = 1'b0;
  endtask

  task automatic check_perm(input int base, input string nm);
    logic [63:0] seen;
    logic [5:0]  c;
    int          bad;
    seen = '0;
    bad  = 0;
    if (log_q.size() < base + DECK) bad = DECK;
    else begin
      for (int k = 0; k < DECK; k++) begin
        c = log_q[base + k];
        if (c[3:0] < 4'd1 || c[3:0] > 4'd13 || seen[c]) bad++;
        seen[c] = 1'b1;
      end
    end
    check(bad == 0, nm, bad, 0);
  endtask

  initial begin
    int n;
    int base;
    int base_a;
    int errs0;
    int bad;
    logic [5:0] last;

    // Reset and first shuffle
    @(posedge clock); #1 reset = 1'b0;
    check_reset_state("reset_state");
    wait_ready("first_ready", n);
    check(n >= DECK + 51, "busy_cycles", n, DECK + 51);
    check(cards_left == 6'd52, "ready_cards_left", cards_left, 52);
    check(empty == 1'b0, "ready_not_empty", empty, 0);
    check(card_rank == 4'd0, "ready_rank_zero", card_rank, 0);

    // Full deal, spaced 3 cycles
    base = log_q.size();
    for (int k = 0; k < DECK; k++) begin
      draw(DECK - 1 - k);
      tick(1);
    end
    tick(3);
    check(log_q.size() == base + DECK, "deal1_count", log_q.size() - base, DECK);
    check_perm(base, "deal1_perm");
    bad = 0;
    if (log_q.size() >= base + 13)
      for (int k = 0; k < 13; k++) if (log_q[base + k] != 6'(k + 1)) bad++;
    check(bad != 0, "deal1_not_identity", bad, 1);
    check(empty == 1'b1 && cards_left == 6'd0, "empty_after_52", {empty, cards_left}, 64);
    last = (log_q.size() > 0) ? log_q[log_q.size() - 1] : 6'd0;

    // 53rd draw from an empty shoe
    errs0 = err_cnt;
    @(posedge clock); #1 draw_req = 1'b1;
    @(posedge clock); #1 draw_req = 1'b0;
    check(draw_err == 1'b1, "draw_err_pulse", draw_err, 1);
    check({card_suit, card_rank} == last, "hold_last_card", {card_suit, card_rank}, last);
    check(cards_left == 6'd0 && ready == 1'b1, "empty_stays_ready", {ready, cards_left}, 64);
    tick(1);
    check(draw_err == 1'b0, "draw_err_one_cycle", draw_err, 0);
    check(err_cnt - errs0 == 1, "draw_err_count", err_cnt - errs0, 1);

    // Reshuffle, 10 draws, then shuffle and draw in the same cycle
    @(posedge clock); #1 shuffle_req = 1'b1;
    @(posedge clock); #1 shuffle_req = 1'b0;
    check(ready == 1'b0 && cards_left == 6'd0, "shuffle_busy", {ready, cards_left}, 0);
    wait_ready("reshuffle_ready", n);
    for (int k = 0; k < 10; k++) begin
      draw(DECK - 1 - k);
      tick(1);
    end
    tick(2);
    check(cards_left == 6'd42, "after_10_draws", cards_left, 42);
    @(posedge clock); #1 shuffle_req = 1'b1; draw_req = 1'b1;
    @(posedge clock); #1 shuffle_req = 1'b0; draw_req = 1'b0;
    check(ready == 1'b0 && card_valid == 1'b0 && cards_left == 6'd0,
          "shuffle_beats_draw", {ready, card_valid, cards_left}, 0);

    // Held draw while busy shuffling
    tick(55);
    errs0 = err_cnt;
    bad = 0;
    draw_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (ready || cards_left != 6'd0 || draw_err || card_valid) bad++;
    end
    draw_req = 1'b0;
    check(bad == 0, "draw_ignored_busy", bad, 0);
    check(err_cnt == errs0, "no_err_busy", err_cnt - errs0, 0);
    wait_ready("post_busy_ready", n);
    check(cards_left == 6'd52, "reshuffle_full", cards_left, 52);
    base = log_q.size();
    for (int k = 0; k < DECK; k++) begin
      draw(DECK - 1 - k);
      tick(1);
    end
    tick(3);
    check_perm(base, "deal2_perm");

    // Reset mid-shuffle, then determinism check
    do_reset();
    tick(70);
    check(ready == 1'b0, "mid_shuffle_busy", ready, 0);
    do_reset();
    check_reset_state("reset_mid_shuffle");
    wait_ready("ready_a", n);
    base_a = log_q.size();
    for (int k = 0; k < 5; k++) begin
      draw(DECK - 1 - k);
      tick(1);
    end
    tick(3);
    do_reset();
    check_reset_state("reset_after_draws");
    wait_ready("ready_b", n);
    base = log_q.size();
    for (int k = 0; k < 5; k++) begin
      draw(DECK - 1 - k);
      tick(1);
    end
    tick(3);
    bad = 0;
    if (log_q.size() < base + 5) bad = 5;
    else
      for (int k = 0; k < 5; k++) begin
        if (log_q[base + k] != log_q[base_a + k]) bad++;
        if (log_q[base_a + k] != log_q[k]) bad++;
      end
    check(bad == 0, "repeatable_deal", bad, 0);
    check(exp_q.size() == 0, "no_missing_valid", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
